// File: rtl/i2c_slave_rx_if.sv
// Bus-side and receive-side signals of the write-only I2C slave receiver.
// The master modport is the bus/consumer view, the slave modport the receiver view.
interface i2c_slave_rx_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       bus_busy;

    modport master (
        output scl,
        output sda_in,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  addr_match,
        input  bus_busy
    );

    modport slave (
        input  scl,
        input  sda_in,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output addr_match,
        output bus_busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: oversampled SCL/SDA, START/STOP detection, address match,
// ACK of address and data bytes, and a one-cycle strobe per received byte.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    i2c_slave_rx_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    logic [6:0] shift_q;
    logic [2:0] bit_cnt;
    logic       ack_drive;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, addr_match_q, bus_busy_q;

    logic       sda_oe_c, shift_en, byte_done, ack_set, ack_done;

    // Synchronizers and history flops preset to the idle-bus level so reset release is event-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Bus conditions override bit-level progress in whatever state we are in.
    always_comb begin
        next_state = state;
        if (stop_ev) begin
            next_state = IDLE;
        end else if (start_ev) begin
            next_state = ADDR;
        end else begin
            case (state)
                IDLE:     next_state = IDLE;
                ADDR: begin
                    if (scl_rise && bit_cnt == 3'd7) begin
                        if (shift_q == SLAVE_ADDR && !sda_s) next_state = ADDR_ACK;
                        else                                  next_state = IGNORE;
                    end
                end
                ADDR_ACK: if (ack_done) next_state = DATA;
                DATA:     if (scl_rise && bit_cnt == 3'd7) next_state = DATA_ACK;
                DATA_ACK: if (ack_done) next_state = DATA;
                IGNORE:   next_state = IGNORE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe_c  = ack_drive && (state == ADDR_ACK || state == DATA_ACK);
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ack_set   = 1'b0;
        ack_done  = 1'b0;
        if (!start_ev && !stop_ev) begin
            shift_en  = scl_rise && (state == ADDR || state == DATA);
            byte_done = shift_en && bit_cnt == 3'd7 && state == DATA;
            ack_set   = scl_fall && !ack_drive && (state == ADDR_ACK || state == DATA_ACK);
            ack_done  = scl_fall &&  ack_drive && (state == ADDR_ACK || state == DATA_ACK);
        end
    end

    // ACK is driven from the SCL fall that ends bit 8 to the fall that ends bit 9.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q      <= '0;
            bit_cnt      <= '0;
            ack_drive    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else begin
            rx_valid_q <= byte_done;
            if (stop_ev) begin
                bit_cnt      <= '0;
                ack_drive    <= 1'b0;
                addr_match_q <= 1'b0;
                bus_busy_q   <= 1'b0;
            end else if (start_ev) begin
                bit_cnt      <= '0;
                ack_drive    <= 1'b0;
                addr_match_q <= 1'b0;
                bus_busy_q   <= 1'b1;
            end else begin
                if (shift_en) begin
                    shift_q <= {shift_q[5:0], sda_s};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) rx_data_q <= {shift_q, sda_s};
                if (ack_set) begin
                    ack_drive <= 1'b1;
                    if (state == ADDR_ACK) addr_match_q <= 1'b1;
                end
                if (ack_done) ack_drive <= 1'b0;
            end
        end
    end

    assign bus.sda_oe     = sda_oe_c;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.addr_match = addr_match_q;
    assign bus.bus_busy   = bus_busy_q;

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Write-only I2C slave receiver, the downstream peer of the I2C master on the shared SCL/SDA bus. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit address. It ACKs the address and each data byte and presents each received byte on a one-cycle valid strobe. It is used as the bus-side endpoint in master/slave loopback benches and as the register-write front end.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
SYNC_STAGES, 2, flip-flop stages in the SCL/SDA input synchronizers (minimum 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
scl  input  1  bus clock from master (open-drain line, read only).
sda_in  input  1  bus data line as seen on the wire.
sda_oe  output  1  1 = pull SDA low (ACK); 0 = release. Top level ties SDA to 0 when sda_oe=1, else Z.
rx_data  output  8  last received data byte; holds until the next byte completes.
rx_valid  output  1  one-clk pulse when rx_data updates.
addr_match  output  1  high from address-ACK until the next STOP/START.
bus_busy  output  1  high between a detected START and the next STOP.

Behaviour:
- Reset (reset=0, async): sda_oe=0, rx_data=8'h00, rx_valid=0, addr_match=0, bus_busy=0, state=IDLE, bit counter=0, synchronizers preset to 1 (idle bus).
- Input path: scl and sda_in each pass through SYNC_STAGES flops, plus one history flop for edge detection. Raw lines are never used in logic.
- Events, all on synchronized signals:
  - SCL_RISE / SCL_FALL: from the edges of synchronized SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START and STOP take priority over any bit sampling in the same cycle.
- Data is sampled MSB first on SCL_RISE. Bit counter is 0..7 and wraps to 0 after bit 7.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: START -> ADDR, bus_busy=1, counter=0.
  - ADDR: shift 8 bits. On the 8th SCL_RISE, compare bits[7:1] with SLAVE_ADDR; bit0 is R/W.
    - Match and R/W=0 -> ADDR_ACK.
    - Mismatch or R/W=1 -> IGNORE. Reads are not supported and are NACKed by leaving SDA released.
  - ADDR_ACK: assert sda_oe on the first SCL_FALL after entry. Set addr_match=1. Release sda_oe on the following SCL_FALL (end of 9th clock), then -> DATA.
  - DATA: shift 8 bits. On the 8th SCL_RISE, load rx_data and pulse rx_valid for exactly one clk on the next cycle, then -> DATA_ACK.
  - DATA_ACK: same sda_oe timing as ADDR_ACK, then -> DATA for the next byte.
  - IGNORE: sda_oe held 0, no rx_valid. Wait for START or STOP.
- START in any non-IDLE state (repeated START): release sda_oe, clear addr_match, counter=0 -> ADDR. bus_busy stays 1.
- STOP in any state: release sda_oe, clear addr_match and bus_busy, counter=0 -> IDLE.
  - A partial byte is discarded: no rx_valid and rx_data unchanged.
- No backpressure: every completed data byte is ACKed and strobed. The consumer must accept rx_valid on the cycle it occurs.
- sda_oe is only ever asserted during an ACK slot. Asserting it at any other time is an error.
- Async reset mid-transfer immediately releases sda_oe and returns to IDLE. After release, the block ignores bus activity until the next START.
- The block assumes SCL high/low phases of at least SYNC_STAGES+2 clk periods.

Test Plan:
1. START, addr 0x50+W (0xA0), data 0xA5, 0x5A, STOP -> sda_oe low in 3 ACK slots; rx_valid pulses twice with rx_data=0xA5 then 0x5A; addr_match high from first ACK until STOP; bus_busy low after STOP.
2. START, addr byte 0xA2 (addr 0x51), data 0xAA, STOP -> sda_oe never asserted, no rx_valid, addr_match stays 0, rx_data holds previous value.
3. START, 0xA1 (addr 0x50, read) -> NACK (sda_oe=0 in 9th clock), state IGNORE, no rx_valid until STOP.
4. START, 0xA0, data 0x3C, repeated START, 0xA0, data 0xC3, STOP -> 4 ACKs; rx_valid with 0x3C then 0xC3; addr_match drops for the repeated-START address phase and reasserts at its ACK.
5. START, 0xA0, 4 bits of 0xF0, then STOP -> no rx_valid, rx_data unchanged, sda_oe=0, FSM in IDLE, bus_busy=0.
6. reset driven 0 during a DATA_ACK slot (sda_oe=1) -> sda_oe=0 in the same cycle and all outputs at reset values. After reset=1 with a full transfer START, 0xA0, 0x99, STOP -> rx_data=0x99 with a single rx_valid.
